// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the instruction buffer between fetch and decode.
// Optional feature macro: INST_BUFFER_BYPASS_EN (see inst_buffer.sv).
package inst_buffer_pkg;

    localparam int INST_BUF_DEPTH = 8;

    // One fetched instruction as carried from frontend to backend.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [27:0] bpu_predict;
        logic [3:0]  fetch_excp;
    } inst_t;

    localparam int INST_W = $bits(inst_t);

    // Encoding of the backend's per-cycle consume count.
    localparam logic [1:0] ISSUE_NONE = 2'd0;
    localparam logic [1:0] ISSUE_ONE  = 2'd1;
    localparam logic [1:0] ISSUE_TWO  = 2'd2;

    // The backend never takes more than two; an encoding of 3 means two.
    function automatic logic [1:0] clamp_issue(input logic [1:0] n);
        return (n > ISSUE_TWO) ? ISSUE_TWO : n;
    endfunction

    // Number of pushed lanes; lane1 without lane0 is illegal and counts as none.
    function automatic logic [1:0] lane_count(input logic [1:0] v);
        return (v == 2'b11) ? ISSUE_TWO : (v == 2'b01) ? ISSUE_ONE : ISSUE_NONE;
    endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Frontend/backend handshake bundle of the instruction buffer.
// Optional feature macro: INST_BUFFER_BYPASS_EN (affects behaviour only, not this bundle).
interface inst_buffer_if
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH  = INST_BUF_DEPTH,
    parameter int DATA_W = INST_W
);
    logic                    flush_i;
    logic [1:0]              in_valid_i;
    logic [2*DATA_W-1:0]     in_data_i;
    logic                    in_ready_o;
    logic [1:0]              out_valid_o;
    logic [2*DATA_W-1:0]     out_data_o;
    logic [1:0]              issue_num_i;
    logic [$clog2(DEPTH):0]  count_o;

    // Surrounding pipeline (frontend push side plus backend pop side).
    modport master (
        output flush_i, in_valid_i, in_data_i, issue_num_i,
        input  in_ready_o, out_valid_o, out_data_o, count_o
    );

    // The buffer itself.
    modport slave (
        input  flush_i, in_valid_i, in_data_i, issue_num_i,
        output in_ready_o, out_valid_o, out_data_o, count_o
    );
endinterface

// File: rtl/inst_buffer_ram.sv
// Circular payload store: two writes and two asynchronous reads, each pair at
// consecutive addresses wrapping modulo DEPTH.
// Optional feature macro: INST_BUFFER_BYPASS_EN (not used here).
module inst_buffer_ram
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH  = INST_BUF_DEPTH,
    parameter int DATA_W = INST_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [1:0]        we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     waddr1;
    logic [AW-1:0]     raddr1;

    // DEPTH is a power of two, so natural overflow is the modulo wrap.
    assign waddr1 = waddr + AW'(1);
    assign raddr1 = raddr + AW'(1);

    // Write the two incoming lanes into consecutive slots.
    // NOTE: payloads carry no reset; whether a slot holds live data is decided by the occupancy count alone.
    always_ff @(posedge clk) begin
        if (we[0]) mem[waddr]  <= wdata0;
        if (we[1]) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_buffer.sv
// Dual-lane instruction buffer between fetch and decode: accepts 0-2 entries
// per cycle, presents the oldest two, pops 0-2 per cycle, flushed on redirect.
// Optional feature macro: INST_BUFFER_BYPASS_EN -- when defined, an empty buffer
// forwards the incoming lanes to the outputs in the same cycle and does not
// store lanes the backend consumes immediately.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH  = INST_BUF_DEPTH,
    parameter int DATA_W = INST_W
) (
    input  logic        clk,
    input  logic        rst,
    inst_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]     head_ptr;
    logic [AW-1:0]     tail_ptr;
    logic [CW-1:0]     count;

    logic              in_ready;
    logic              bypass;
    logic [1:0]        issue_eff;
    logic [1:0]        push_n;
    logic [1:0]        avail;
    logic [1:0]        pop_n;
    logic [1:0]        head_adv;
    logic [1:0]        store_n;
    logic [1:0]        we;
    logic [DATA_W-1:0] in_lane0;
    logic [DATA_W-1:0] in_lane1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    assign in_lane0 = bus.in_data_i[DATA_W-1:0];
    assign in_lane1 = bus.in_data_i[2*DATA_W-1:DATA_W];

    // Readiness looks at pre-pop occupancy, so a pop never opens room in the same cycle.
    assign in_ready  = (DEPTH_C - count) >= CW'(2);
    assign issue_eff = clamp_issue(bus.issue_num_i);
    assign push_n    = in_ready ? lane_count(bus.in_valid_i) : ISSUE_NONE;

`ifdef INST_BUFFER_BYPASS_EN
    assign bypass = (count == '0) && !bus.flush_i;
`else
    assign bypass = 1'b0;
`endif

    // Decide how many entries leave the head and how many lanes land at the tail.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        avail    = (count >= CW'(2)) ? 2'd2 : count[1:0];
        wdata0   = in_lane0;
        wdata1   = in_lane1;
        we       = 2'b00;
        if (bypass) avail = push_n;
        pop_n    = (issue_eff < avail) ? issue_eff : avail;
        head_adv = bypass ? ISSUE_NONE : pop_n;
        store_n  = bypass ? (push_n - pop_n) : push_n;
        // A bypassed lane0 that was consumed leaves lane1 as the first stored entry.
        if (bypass && (pop_n == ISSUE_ONE)) wdata0 = in_lane1;
        if (!bus.flush_i) we = {store_n == ISSUE_TWO, store_n != ISSUE_NONE};
    end

    // Pointer and occupancy registers; reset outranks flush, both empty the queue.
    // NOTE: non-blocking assignments make all three registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + AW'(head_adv);
            tail_ptr <= tail_ptr + AW'(store_n);
            count    <= count + CW'(store_n) - CW'(head_adv);
        end
    end

    inst_buffer_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr  (tail_ptr),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .raddr  (head_ptr),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    // Present the two oldest entries, or the incoming lanes when bypassing an empty buffer.
    always_comb begin
        bus.out_valid_o = {count >= CW'(2), count != '0};
        bus.out_data_o  = {rdata1, rdata0};
        if (bypass) begin
            bus.out_valid_o = {push_n == ISSUE_TWO, push_n != ISSUE_NONE};
            bus.out_data_o  = bus.in_data_i;
        end
    end

    assign bus.in_ready_o = in_ready;
    assign bus.count_o    = count;

    // The backend asked for more than is presented; the pop is clamped.
    a_no_overrequest : assert property (@(posedge clk) disable iff (rst)
        !bus.flush_i |-> (bus.issue_num_i <= avail))
        else $warning("inst_buffer: issue_num exceeds presented entries, clamped");

    // Lane1 without lane0 is not a legal push; it is ignored.
    a_lane_order : assert property (@(posedge clk) disable iff (rst)
        bus.in_valid_i != 2'b10)
        else $warning("inst_buffer: in_valid 2'b10 ignored");

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer (default build, INST_BUFFER_BYPASS_EN undefined).
// Reference model: a queue of instructions updated from the buffer's rules.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH  = INST_BUF_DEPTH;
    localparam int DATA_W = INST_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    inst_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    inst_t model_q[$];
    inst_t idle_inst = '0;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic inst_t make_inst(input int id);
        inst_t t;
        t.pc          = 32'h8000_0000 | (32'(id) << 2);
        t.instr       = $urandom;
        t.bpu_predict = 28'($urandom);
        t.fetch_excp  = 4'($urandom);
        return t;
    endfunction

    // Compare the registered-state outputs against the model queue.
    task automatic check_state();
        int n = model_q.size();
        check("count", 128'(bus.count_o), 128'(n));
        check("in_ready", 128'(bus.in_ready_o), 128'((DEPTH - n) >= 2));
        check("out_valid", 128'(bus.out_valid_o), 128'({n >= 2, n >= 1}));
        if (n >= 1) check("lane0", 128'(bus.out_data_o[DATA_W-1:0]), 128'(model_q[0]));
        if (n >= 2) check("lane1", 128'(bus.out_data_o[2*DATA_W-1:DATA_W]), 128'(model_q[1]));
    endtask

    // Check current outputs, drive one cycle of stimulus, advance the model and the clock.
    task automatic apply(input logic [1:0] v, input inst_t d0, input inst_t d1,
                         input logic [1:0] iss, input logic fl);
        int n     = model_q.size();
        bit ready = (DEPTH - n) >= 2;
        int pops;
        check_state();
        bus.in_valid_i  = v;
        bus.in_data_i   = {d1, d0};
        bus.issue_num_i = iss;
        bus.flush_i     = fl;
        if (rst || fl) begin
            model_q.delete();
        end else begin
            pops = (iss > 2) ? 2 : int'(iss);
            if (pops > n) pops = n;
            repeat (pops) void'(model_q.pop_front());
            if (ready && v[0])       model_q.push_back(d0);
            if (ready && v == 2'b11) model_q.push_back(d1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] iss);
        apply(2'b00, idle_inst, idle_inst, iss, 1'b0);
    endtask

    task automatic run_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            int         n     = model_q.size();
            int         r     = $urandom_range(0, 9);
            int         maxi  = (n > 2) ? 2 : n;
            bit         hoard = ((i / 150) % 2) == 1;
            logic [1:0] v     = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : 2'b11;
            logic [1:0] iss   = 2'($urandom_range(0, maxi));
            logic       fl    = ($urandom_range(0, 47) == 0);
            if (hoard && $urandom_range(0, 4) != 0) iss = 2'd0;
            apply(v, make_inst(1000 + 2 * i), make_inst(1001 + 2 * i), iss, fl);
        end
    endtask

    initial begin
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 2'b00;
        bus.in_data_i   = '0;
        bus.issue_num_i = 2'd0;
        rst             = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Reset outputs are checked while rst is still high.
        idle(2'd0);
        rst = 1'b0;

        // Fill: four pairs with no pops, ending full with the first pair at the head.
        for (int i = 0; i < 4; i++) apply(2'b11, make_inst(2 * i), make_inst(2 * i + 1), 2'd0, 1'b0);

        // Drain with wrap: pairs pushed while two pop every cycle.
        for (int i = 0; i < 8; i++) apply(2'b11, make_inst(20 + 2 * i), make_inst(21 + 2 * i), ISSUE_TWO, 1'b0);
        for (int i = 0; i < 6; i++) idle(ISSUE_TWO);

        // Full-minus-one refuses a push even when a pop frees room.
        apply(2'b01, make_inst(40), idle_inst, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) apply(2'b11, make_inst(41 + 2 * i), make_inst(42 + 2 * i), 2'd0, 1'b0);
        apply(2'b11, make_inst(50), make_inst(51), ISSUE_ONE, 1'b0);
        apply(2'b11, make_inst(52), make_inst(53), ISSUE_TWO, 1'b0);
        apply(2'b00, idle_inst, idle_inst, 2'd0, 1'b1);

        // Odd pops: X, Y, Z then single pops, finishing with an overrequest at count 1.
        apply(2'b11, make_inst(60), make_inst(61), 2'd0, 1'b0);
        apply(2'b01, make_inst(62), idle_inst, 2'd0, 1'b0);
        idle(ISSUE_ONE);
        idle(ISSUE_ONE);
        idle(ISSUE_TWO);
        idle(2'd0);

        // issue_num of 3 pops only two.
        apply(2'b11, make_inst(70), make_inst(71), 2'd0, 1'b0);
        apply(2'b11, make_inst(72), make_inst(73), 2'd0, 1'b0);
        idle(2'd3);

        // Flush collision: push and pop in the flush cycle are both discarded.
        apply(2'b11, make_inst(80), make_inst(81), 2'd0, 1'b0);
        apply(2'b01, make_inst(82), idle_inst, 2'd0, 1'b0);
        apply(2'b11, make_inst(83), make_inst(84), ISSUE_TWO, 1'b1);
        apply(2'b01, make_inst(85), idle_inst, 2'd0, 1'b0);
        idle(2'd0);

        // Reset mid-burst, together with a flush, empties everything.
        apply(2'b11, make_inst(90), make_inst(91), 2'd0, 1'b0);
        rst = 1'b1;
        apply(2'b11, make_inst(92), make_inst(93), ISSUE_ONE, 1'b1);
        rst = 1'b0;
        apply(2'b11, make_inst(94), make_inst(95), 2'd0, 1'b0);
        idle(ISSUE_ONE);

        run_random(1500);
        check_state();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Dual-lane decoupling queue between the frontend fetch output and the backend issue/decode input.
- Absorbs fetch bursts and backend stalls; accepts 0–2 instructions per cycle and presents the oldest two to the backend.
- The backend pops 0–2 per cycle via issue_num. Flushed on redirect (branch mispredict, exception, ertn, idle wake).

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- DATA_W, 96, width of one packed instruction payload (inst_t: pc, instruction word, bpu_predict, fetch-exception bits).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- flush_i  input  1  discard all contents; highest priority
- in_valid_i  input  2  per-lane push valid from frontend; lane1 valid only if lane0 valid
- in_data_i  input  2*DATA_W  lane0 in [DATA_W-1:0], lane1 in upper half
- in_ready_o  output  1  free entries >= 2; frontend pushes only when high
- out_valid_o  output  2  head entries valid; out_valid_o[1] implies out_valid_o[0]
- out_data_o  output  2*DATA_W  oldest entry on lane0, next-oldest on lane1
- issue_num_i  input  2  entries consumed by backend this cycle (0, 1, 2)
- count_o  output  $clog2(DEPTH)+1  current occupancy, for perf counters and backend_stall gating

Behaviour:
- Storage: circular array, DEPTH entries. Registered head_ptr and tail_ptr of width $clog2(DEPTH), wrapping modulo DEPTH. Registered count of width $clog2(DEPTH)+1.
- Reset (rst=1 at posedge): head_ptr=0, tail_ptr=0, count=0. Entry payloads are not reset.
- Output values during and after reset: out_valid_o=2'b00, in_ready_o=1, count_o=0. out_data_o is don't-care while its valid bit is low.
- Combinational outputs, all derived from registered state:
  - out_valid_o[0] = (count>=1); out_valid_o[1] = (count>=2).
  - out_data_o lane0 = mem[head_ptr]; lane1 = mem[head_ptr+1 mod DEPTH].
  - in_ready_o = (DEPTH - count >= 2).
- pop_n = min(issue_num_i, count), and never more than 2. issue_num_i=3 is treated as 2. Overrequest is clamped and flagged by assertion.
- push_n = popcount(in_valid_i) when in_ready_o=1, else 0; data is dropped if in_ready_o=0. Lane0 is written at tail_ptr, lane1 at tail_ptr+1. in_valid_i=2'b10 is illegal: assertion, treated as 0.
- Next state: head_ptr += pop_n; tail_ptr += push_n; count += push_n - pop_n.
  - Push and pop in the same cycle are allowed, including pop-all with push-2 when count=2.
  - in_ready_o is evaluated before the pop, so a full-minus-1 buffer does not accept even if a pop frees space.
- Flush: on flush_i=1, head_ptr=tail_ptr=0 and count=0 next cycle. Same-cycle push and pop are ignored. Outputs show empty from the following cycle.
- Latency: an entry pushed at edge N is visible on out_* after edge N (1 cycle), without bypass.
- Boundaries:
  - count=DEPTH-1: in_ready_o=0.
  - count=DEPTH: in_ready_o=0. A pop of 2 makes in_ready_o=1 next cycle.
  - Pointer wrap across DEPTH-1 to 0 must keep lane ordering intact.
- rst takes priority over flush_i. Reset asserted mid-burst discards everything.

Optional Feature:
- Macro: INST_BUFFER_BYPASS_EN.
- Defined: when count=0 and flush_i=0, the in_* lanes drive out_* combinationally in the same cycle (out_valid_o=in_valid_i & {2{in_ready_o}}).
  - Lanes consumed by issue_num_i are not written to storage; unconsumed lanes are written normally.
  - Zero-latency for an empty buffer.
- Undefined: 1-cycle minimum latency as above; no in→out combinational path.

Decomposition:
- Shared package: INST_BUF_DEPTH default and the inst_t payload typedef, so DATA_W = $bits(inst_t).
- Shared package: issue_num encoding constants ISSUE_NONE=0, ISSUE_ONE=1, ISSUE_TWO=2.
- Sub-module inst_buffer_ram: DEPTH x DATA_W, two write ports at consecutive addresses, two asynchronous read ports at consecutive addresses. Pointer and count control stays in inst_buffer.

Test Plan:
- Reset then fill: push 2'b11 for 4 cycles with payloads A..H, issue_num=0 → count_o=8, in_ready_o=0 after cycle 3; out lanes show A, B.
- Drain with wrap: from the full state, push 2'b11 I, J each cycle with issue_num=2 → out sequence (A,B),(C,D)…; I, J stored at indices 0,1 after the pointer wraps; order preserved.
- Odd pops: count=3 (X, Y, Z), issue_num=1 twice → out (X,Y), then (Y,Z), then (Z,-) with out_valid_o=2'b01.
- Overrequest: count=1, issue_num=2 → count_o=0 next cycle, no underflow, assertion fires.
- Flush collision: count=5, flush_i=1 with push 2'b11 and issue_num=2 → count_o=0, out_valid_o=2'b00 next cycle; following push of P at count 0 appears alone.
- Bypass (INST_BUFFER_BYPASS_EN): empty buffer, push Q, R with issue_num=1 → out lanes show Q, R the same cycle; count_o=1 next cycle with R at head.
